// File: rtl/joybus_pkg.sv
// joybus_pkg: shared Joybus definitions.
//   - rx_state_e : receive FSM state encoding
//   - BIT_CYC, QUARTER_CYC, SAMPLE_CYC : bit-cell timing at 25 MHz (also used by the transmitter)
//   - NBITS_DEFAULT : default response length (poll response)
package joybus_pkg;

    localparam int unsigned BIT_CYC       = 100;
    localparam int unsigned QUARTER_CYC   = 25;
    localparam int unsigned SAMPLE_CYC    = 50;
    localparam int unsigned NBITS_DEFAULT = 32;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_WAIT_FALL,
        RX_SAMPLE,
        RX_WAIT_HIGH,
        RX_STOP_FALL,
        RX_STOP_RISE,
        RX_DONE
    } rx_state_e;

endpackage

// File: rtl/joybus_resp_rx_if.sv
// joybus_resp_rx_if: host-side signals of the Joybus response receiver.
//   JB_RX          raw line level (async)
//   rx_start       one-cycle arm pulse (from the transmitter's tx_done)
//   jb_cntlr_data  last successfully received frame
//   rx_done        one-cycle frame-complete pulse
//   rx_err         one-cycle frame-aborted pulse
//   rx_busy        receiver armed
// Modports: slave = receiver, master = host/driver side.
interface joybus_resp_rx_if import joybus_pkg::*; #(
    parameter int unsigned NBITS = NBITS_DEFAULT
);
    logic             JB_RX;
    logic             rx_start;
    logic [NBITS-1:0] jb_cntlr_data;
    logic             rx_done;
    logic             rx_err;
    logic             rx_busy;

    modport slave (
        input  JB_RX, rx_start,
        output jb_cntlr_data, rx_done, rx_err, rx_busy
    );

    modport master (
        output JB_RX, rx_start,
        input  jb_cntlr_data, rx_done, rx_err, rx_busy
    );
endinterface

// File: rtl/joybus_line_sync.sv
// joybus_line_sync: 2-flop synchronizer for the Joybus line plus a registered
// previous value for edge detection.
//   clk, rst_n : clock, async active-low reset
//   line_i     : raw asynchronous line
//   line_o     : synchronized level
//   fall_o     : synchronized 1->0 transition
//   rise_o     : synchronized 0->1 transition
// All flops reset to 1 (idle-high line).
module joybus_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o,
    output logic fall_o,
    output logic rise_o
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign line_o = sync2_q;
    assign fall_o = prev_q & ~sync2_q;
    assign rise_o = ~prev_q & sync2_q;
endmodule

// File: rtl/joybus_resp_rx.sv
// joybus_resp_rx: Joybus host receive stage. Armed by rx_start, decodes an
// NBITS MSB-first response frame plus stop bit into jb_cntlr_data.
//   clk, rst_n : 25 MHz clock, async active-low reset
//   bus        : joybus_resp_rx_if.slave (JB_RX, rx_start, jb_cntlr_data,
//                rx_done, rx_err, rx_busy)
// Optional feature: define JOYBUS_RX_TIMEOUT_EN to build the TIMEOUT_CYC
// watchdog; otherwise rx_err is tied to 0 and the receiver waits forever.
module joybus_resp_rx #(
    parameter int unsigned NBITS       = joybus_pkg::NBITS_DEFAULT,
    parameter int unsigned SAMPLE_CYC  = joybus_pkg::SAMPLE_CYC,
    parameter int unsigned TIMEOUT_CYC = 2500
) (
    input  logic             clk,
    input  logic             rst_n,
    joybus_resp_rx_if.slave  bus
);
    import joybus_pkg::*;

    localparam int unsigned CW = $clog2(SAMPLE_CYC + 1);
    localparam int unsigned BW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYC - 1);
    localparam logic [BW-1:0] BITS_ALL    = BW'(NBITS);

    logic line, fall, rise;

    joybus_line_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (bus.JB_RX),
        .line_o (line),
        .fall_o (fall),
        .rise_o (rise)
    );

    rx_state_e        state_q, state_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] data_q,  data_d;
    logic [BW-1:0]    bits_q,  bits_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;

`ifdef JOYBUS_RX_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: if (bus.rx_start) begin
                shift_d = '0;
                bits_d  = '0;
                state_d = RX_WAIT_FALL;
            end
            RX_WAIT_FALL: if (fall) begin
                cnt_d   = '0;
                state_d = RX_SAMPLE;
            end
            RX_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    shift_d = {shift_q[NBITS-2:0], line};
                    bits_d  = bits_q + 1'b1;
                    state_d = RX_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: if (line) begin
                state_d = (bits_q == BITS_ALL) ? RX_STOP_FALL : RX_WAIT_FALL;
            end
            RX_STOP_FALL: if (fall) state_d = RX_STOP_RISE;
            // Data and rx_done are registered on the way into DONE so both are
            // visible during the single DONE cycle.
            RX_STOP_RISE: if (rise) begin
                data_d  = shift_q;
                done_d  = 1'b1;
                state_d = RX_DONE;
            end
            RX_DONE: state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase

`ifdef JOYBUS_RX_TIMEOUT_EN
        // Watchdog runs only while waiting on the line; any edge restarts it.
        wd_d  = '0;
        err_d = 1'b0;
        if ((state_q inside {RX_WAIT_FALL, RX_WAIT_HIGH, RX_STOP_FALL, RX_STOP_RISE})
            && !fall && !rise) begin
            if (wd_q == WD_LAST) begin
                err_d   = 1'b1;
                state_d = RX_IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            shift_q <= '0;
            data_q  <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef JOYBUS_RX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign bus.rx_err = err_q;
`else
    assign bus.rx_err = 1'b0;
`endif

    assign bus.jb_cntlr_data = data_q;
    assign bus.rx_done       = done_q;
    assign bus.rx_busy       = (state_q != RX_IDLE) && (state_q != RX_DONE);
endmodule

// File: tb/tb_joybus_resp_rx.sv
// tb_joybus_resp_rx: self-checking bench for joybus_resp_rx. Frames are driven
// as Joybus bit cells; the expected word is simply the word sent, and the held
// output word is tracked separately (reset clears it, aborts keep it).
module tb_joybus_resp_rx;
    localparam int unsigned NB = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    joybus_resp_rx_if #(.NBITS(NB)) bus ();

    joybus_resp_rx #(
        .NBITS       (NB),
        .SAMPLE_CYC  (50),
        .TIMEOUT_CYC (2500)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [NB-1:0] cap_data = '0;
    logic [NB-1:0] exp_data = '0;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.rx_done) begin
            done_cnt = done_cnt + 1;
            cap_data = bus.jb_cntlr_data;
        end
        if (bus.rx_err) err_cnt = err_cnt + 1;
        if (bus.rx_done && bus.rx_err) both_cnt = both_cnt + 1;
    end

    initial begin
        #(150000 * 40);
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic arm();
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
    endtask

    // zl/ol < 0 selects a random in-tolerance low time per bit.
    task automatic send_bits(input logic [NB-1:0] w, input int hi, input int lo,
                             input int zl, input int ol);
        int low;
        for (int i = hi; i >= lo; i--) begin
            if (w[i]) low = (ol < 0) ? int'($urandom_range(47, 5)) : ol;
            else      low = (zl < 0) ? int'($urandom_range(80, 52)) : zl;
            bus.JB_RX = 1'b0;
            idle(low);
            bus.JB_RX = 1'b1;
            idle(100 - low);
        end
    endtask

    task automatic send_stop();
        bus.JB_RX = 1'b0;
        idle(25);
        bus.JB_RX = 1'b1;
        idle(60);
    endtask

    task automatic test_reset();
        bus.JB_RX = 1'b1;
        bus.rx_start = 1'b0;
        rst_n = 1'b0;
        idle(3);
        total++; if (bus.jb_cntlr_data !== '0) begin bad++; $display("FAIL reset_data: got %h expected 0", bus.jb_cntlr_data); end
        total++; if (bus.rx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.rx_done); end
        total++; if (bus.rx_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", bus.rx_err); end
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.rx_busy); end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        int e0 = err_cnt;
        arm();
        total++; if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_arm: got %b expected 1", bus.rx_busy); end
        send_bits(32'h8000_0001, 31, 0, 75, 25);
        send_stop();
        exp_data = 32'h8000_0001;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        total++; if (cap_data !== exp_data) begin bad++; $display("FAIL basic_data_at_done: got %h expected %h", cap_data, exp_data); end
        total++; if (bus.jb_cntlr_data !== exp_data) begin bad++; $display("FAIL basic_data_held: got %h expected %h", bus.jb_cntlr_data, exp_data); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL basic_err: got %0d expected %0d", err_cnt, e0); end
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b expected 0", bus.rx_busy); end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] words [2];
        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'h0000_0000;
        for (int k = 0; k < 2; k++) begin
            int d0 = done_cnt;
            arm();
            send_bits(words[k], 31, 0, 75, 25);
            send_stop();
            exp_data = words[k];
            total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL b2b_done_count[%0d]: got %0d expected 1", k, done_cnt - d0); end
            total++; if (cap_data !== exp_data) begin bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, cap_data, exp_data); end
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 4; k++) begin
            logic [NB-1:0] w = $urandom;
            int d0 = done_cnt;
            arm();
            send_bits(w, 31, 0, -1, -1);
            send_stop();
            exp_data = w;
            total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rand_done_count[%0d]: got %0d expected 1", k, done_cnt - d0); end
            total++; if (bus.jb_cntlr_data !== exp_data) begin bad++; $display("FAIL rand_data[%0d]: got %h expected %h", k, bus.jb_cntlr_data, exp_data); end
        end
    endtask

    task automatic test_jitter();
        int d0 = done_cnt;
        arm();
        send_bits(32'hA5A5_A5A5, 31, 0, 53, 47);
        send_stop();
        exp_data = 32'hA5A5_A5A5;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL jitter_done_count: got %0d expected 1", done_cnt - d0); end
        total++; if (cap_data !== exp_data) begin bad++; $display("FAIL jitter_data: got %h expected %h", cap_data, exp_data); end
    endtask

    task automatic test_rearm_ignored();
        int d0 = done_cnt;
        arm();
        send_bits(32'h1234_ABCD, 31, 24, -1, -1);
        arm();
        total++; if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL rearm_busy: got %b expected 1", bus.rx_busy); end
        send_bits(32'h1234_ABCD, 23, 0, -1, -1);
        send_stop();
        exp_data = 32'h1234_ABCD;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rearm_done_count: got %0d expected 1", done_cnt - d0); end
        total++; if (cap_data !== exp_data) begin bad++; $display("FAIL rearm_data: got %h expected %h", cap_data, exp_data); end
    endtask

    task automatic test_reset_midframe();
        logic [NB-1:0] w = $urandom;
        int d0;
        arm();
        send_bits(w, 31, 16, -1, -1);
        bus.JB_RX = 1'b0;
        idle(10);
        rst_n = 1'b0;
        idle(2);
        exp_data = '0;
        d0 = done_cnt;
        total++; if (bus.jb_cntlr_data !== exp_data) begin bad++; $display("FAIL midrst_data: got %h expected %h", bus.jb_cntlr_data, exp_data); end
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", bus.rx_busy); end
        total++; if (bus.rx_done !== 1'b0 || bus.rx_err !== 1'b0) begin bad++; $display("FAIL midrst_pulses: got %b%b expected 00", bus.rx_done, bus.rx_err); end
        idle(3);
        rst_n = 1'b1;
        idle(5);
        bus.JB_RX = 1'b1;
        idle(100);
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL midrst_idle_busy: got %b expected 0", bus.rx_busy); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL midrst_no_done: got %0d expected %0d", done_cnt, d0); end
        arm();
        send_bits(32'h0F0F_0F0F, 31, 0, -1, -1);
        send_stop();
        exp_data = 32'h0F0F_0F0F;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL midrst_next_count: got %0d expected 1", done_cnt - d0); end
        total++; if (cap_data !== exp_data) begin bad++; $display("FAIL midrst_next_data: got %h expected %h", cap_data, exp_data); end
    endtask

`ifdef JOYBUS_RX_TIMEOUT_EN
    task automatic test_timeout();
        int d0 = done_cnt;
        int n = 0;
        logic seen = 1'b0;
        logic busy_at = 1'b1;
        bus.JB_RX = 1'b1;
        arm();
        while (!seen && n < 4000) begin
            tick();
            n++;
            if (bus.rx_err) begin seen = 1'b1; busy_at = bus.rx_busy; end
        end
        total++; if (!seen) begin bad++; $display("FAIL to_high_seen: got none expected rx_err within 4000"); end
        total++; if (n < 2497 || n > 2503) begin bad++; $display("FAIL to_high_latency: got %0d expected 2500+-3", n); end
        total++; if (busy_at !== 1'b0) begin bad++; $display("FAIL to_high_busy: got %b expected 0", busy_at); end
        total++; if (bus.jb_cntlr_data !== exp_data) begin bad++; $display("FAIL to_high_data: got %h expected %h", bus.jb_cntlr_data, exp_data); end
        // Line stuck low after bit 10.
        seen = 1'b0;
        n = 0;
        arm();
        send_bits(32'hDEAD_BEEF, 31, 22, -1, -1);
        bus.JB_RX = 1'b0;
        while (!seen && n < 4000) begin
            tick();
            n++;
            if (bus.rx_err) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL to_low_seen: got none expected rx_err within 4000"); end
        idle(2);
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL to_low_busy: got %b expected 0", bus.rx_busy); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL to_low_no_done: got %0d expected %0d", done_cnt, d0); end
        total++; if (bus.jb_cntlr_data !== exp_data) begin bad++; $display("FAIL to_low_data: got %h expected %h", bus.jb_cntlr_data, exp_data); end
        bus.JB_RX = 1'b1;
        idle(200);
    endtask
`else
    task automatic test_no_watchdog();
        logic [NB-1:0] w = $urandom;
        int d0 = done_cnt;
        int e0 = err_cnt;
        bus.JB_RX = 1'b1;
        arm();
        idle(3000);
        total++; if (err_cnt != e0) begin bad++; $display("FAIL nowd_err: got %0d expected %0d", err_cnt, e0); end
        total++; if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL nowd_busy: got %b expected 1", bus.rx_busy); end
        send_bits(w, 31, 0, -1, -1);
        send_stop();
        exp_data = w;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL nowd_done_count: got %0d expected 1", done_cnt - d0); end
        total++; if (cap_data !== exp_data) begin bad++; $display("FAIL nowd_data: got %h expected %h", cap_data, exp_data); end
    endtask
`endif

    initial begin
        bus.JB_RX = 1'b1;
        bus.rx_start = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_random_frames();
        test_jitter();
        test_rearm_ignored();
        test_reset_midframe();
`ifdef JOYBUS_RX_TIMEOUT_EN
        test_timeout();
`else
        test_no_watchdog();
`endif
        total++; if (both_cnt != 0) begin bad++; $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
